// File: rtl/adc_cap_pkg.sv
// Shared types and constants for the ADC capture buffer.
// Optional feature macro: ADC_CAP_TIMESTAMP_EN (trigger timestamp counter).
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    WAIT_TRIG,
    POST,
    DONE
  } cap_state_e;

  localparam int unsigned RD_LAT = 2;
  localparam int unsigned TS_W   = 32;

endpackage

// File: rtl/adc_cap_dpram.sv
// Simple dual-port block RAM: one write port, one registered read port.
// The read port returns pre-write data on a same-address collision.
module adc_cap_dpram #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1300,
  parameter int unsigned AW    = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic             rclr,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Write port; contents are never cleared by reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read port with synchronous clear for out-of-range requests
  always_ff @(posedge clk) begin
    if (rst || rclr) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_ram.sv
// Multi-channel ADC capture buffer: capture FSM on the write port, logical
// (capture-relative) addressing on the registered read port.
// Optional feature macro: ADC_CAP_TIMESTAMP_EN latches a free-running cycle
// counter into trig_ts on the trigger; without it trig_ts is tied to zero.
module adc_capture_ram
  import adc_cap_pkg::*;
#(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned NCH      = 4,
  parameter int unsigned AWIDTH   = 11,
  parameter int unsigned MEM_SIZE = 1300
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  trig,
  input  logic [AWIDTH-1:0]     pre_cnt,
  input  logic [AWIDTH-1:0]     post_cnt,
  input  logic                  s_valid,
  input  logic [NCH*DWIDTH-1:0] s_data,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [AWIDTH-1:0]     start_addr,
  output logic [TS_W-1:0]       trig_ts,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic [NCH*DWIDTH-1:0] rd_data,
  output logic                  rd_valid
);

  localparam int unsigned DW     = NCH * DWIDTH;
  localparam int unsigned SW     = AWIDTH + 1;
  localparam int unsigned RAM_AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1;
  localparam logic [SW-1:0]     MEM_SIZE_S = SW'(MEM_SIZE);
  localparam logic [AWIDTH-1:0] LAST_ADDR  = AWIDTH'(MEM_SIZE - 1);

  cap_state_e        state_q, state_d;
  logic [AWIDTH-1:0] pre_q, pre_d, post_q, post_d;
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, fill_q, fill_d, remain_q, remain_d;
  logic [AWIDTH-1:0] start_q, start_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;
  logic              we_c;
  logic [SW-1:0]     cfg_sum_c, rot_c, rd_sum_c;
  logic [AWIDTH-1:0] start_rot_c;

  logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
  logic [RAM_AW-1:0] rd_phys_q, rd_phys_d;
  logic              rd_oob_q, rd_oob_d;

  // Capture FSM next state, pointer/counter updates and write enable
  always_comb begin
    state_d   = state_q;
    pre_d     = pre_q;
    post_d    = post_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    remain_d  = remain_q;
    start_d   = start_q;
    cfg_err_d = 1'b0;
    we_c      = 1'b0;

    cfg_sum_c   = {1'b0, pre_cnt} + {1'b0, post_cnt};
    rot_c       = {1'b0, wr_ptr_q} + MEM_SIZE_S - {1'b0, pre_q};
    start_rot_c = (rot_c >= MEM_SIZE_S) ? AWIDTH'(rot_c - MEM_SIZE_S) : AWIDTH'(rot_c);

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (arm) begin
            if (cfg_sum_c > MEM_SIZE_S) begin
              cfg_err_d = 1'b1;
            end else begin
              pre_d    = pre_cnt;
              post_d   = post_cnt;
              wr_ptr_d = '0;
              fill_d   = '0;
              state_d  = PRE;
            end
          end
        end
        PRE: begin
          we_c = s_valid;
          if (fill_q == pre_q) begin
            state_d = WAIT_TRIG;
          end else if (s_valid) begin
            fill_d = fill_q + AWIDTH'(1);
          end
        end
        WAIT_TRIG: begin
          if (trig) begin
            start_d = start_rot_c;
            if (post_q == '0) begin
              state_d = DONE;
            end else begin
              we_c     = s_valid;
              remain_d = s_valid ? (post_q - AWIDTH'(1)) : post_q;
              state_d  = (s_valid && (post_q == AWIDTH'(1))) ? DONE : POST;
            end
          end else begin
            we_c = s_valid;
          end
        end
        POST: begin
          we_c = s_valid;
          if (s_valid) begin
            remain_d = remain_q - AWIDTH'(1);
            if (remain_q == AWIDTH'(1)) begin
              state_d = DONE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (we_c) begin
      wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : (wr_ptr_q + AWIDTH'(1));
    end

    busy_d = (state_d == PRE) || (state_d == WAIT_TRIG) || (state_d == POST);
    done_d = (state_d == DONE);
  end

  // Capture state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pre_q     <= '0;
      post_q    <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      remain_q  <= '0;
      start_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= pre_d;
      post_q    <= post_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      remain_q  <= remain_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Read stage 1: rotate the logical index onto the physical address
  always_comb begin
    rd_sum_c  = {1'b0, start_q} + {1'b0, rd_addr};
    rd_phys_d = RAM_AW'((rd_sum_c >= MEM_SIZE_S) ? (rd_sum_c - MEM_SIZE_S) : rd_sum_c);
    rd_oob_d  = rd_en && ({1'b0, rd_addr} >= MEM_SIZE_S);
    rd_vld_d  = {rd_vld_q[RD_LAT-2:0], rd_en};
  end

  // Read pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q  <= '0;
      rd_phys_q <= '0;
      rd_oob_q  <= 1'b0;
    end else begin
      rd_vld_q  <= rd_vld_d;
      rd_phys_q <= rd_phys_d;
      rd_oob_q  <= rd_oob_d;
    end
  end

  adc_cap_dpram #(
    .WIDTH (DW),
    .DEPTH (MEM_SIZE),
    .AW    (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we_c && !rst),
    .waddr (RAM_AW'(wr_ptr_q)),
    .wdata (s_data),
    .re    (rd_vld_q[0] && !rd_oob_q),
    .rclr  (rd_vld_q[0] && rd_oob_q),
    .raddr (rd_phys_q),
    .rdata (rd_data)
  );

`ifdef ADC_CAP_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d, trig_ts_q, trig_ts_d;

  // Free-running cycle counter, sampled on an accepted trigger
  always_comb begin
    ts_cnt_d  = ts_cnt_q + TS_W'(1);
    trig_ts_d = trig_ts_q;
    if ((state_q == WAIT_TRIG) && trig && !abort) begin
      trig_ts_d = ts_cnt_q;
    end
  end

  // Timestamp registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt_q  <= '0;
      trig_ts_q <= '0;
    end else begin
      ts_cnt_q  <= ts_cnt_d;
      trig_ts_q <= trig_ts_d;
    end
  end

  assign trig_ts = trig_ts_q;
`else
  assign trig_ts = '0;
`endif

  assign busy       = busy_q;
  assign done       = done_q;
  assign cfg_err    = cfg_err_q;
  assign start_addr = start_q;
  assign rd_valid   = rd_vld_q[RD_LAT-1];

endmodule

// File: tb/tb_adc_capture_ram.sv
// Directed bench for adc_capture_ram with a 16-word buffer.
module tb_adc_capture_ram;

  localparam int unsigned DWIDTH   = 8;
  localparam int unsigned NCH      = 2;
  localparam int unsigned AWIDTH   = 5;
  localparam int unsigned MEM_SIZE = 16;
  localparam int unsigned DW       = NCH * DWIDTH;
`ifdef ADC_CAP_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, arm, abort, trig, s_valid, rd_en;
  logic [AWIDTH-1:0] pre_cnt, post_cnt, rd_addr;
  logic [DW-1:0]     s_data;
  logic              busy, done, cfg_err, rd_valid;
  logic [AWIDTH-1:0] start_addr;
  logic [31:0]       trig_ts;
  logic [DW-1:0]     rd_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] cyc = '0;
  logic [31:0] exp_ts;

  adc_capture_ram #(
    .DWIDTH(DWIDTH), .NCH(NCH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .trig(trig),
    .pre_cnt(pre_cnt), .post_cnt(post_cnt), .s_valid(s_valid), .s_data(s_data),
    .busy(busy), .done(done), .cfg_err(cfg_err), .start_addr(start_addr),
    .trig_ts(trig_ts), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  // Reset-relative cycle count, mirrors the optional timestamp counter
  always @(posedge clk) cyc <= rst ? 32'd0 : cyc + 32'd1;

  function automatic logic [DW-1:0] smp(input int i);
    logic [7:0] lo;
    lo = 8'(i);
    return {lo ^ 8'hA5, lo};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int idx, input logic t);
    s_valid = 1'b1;
    s_data  = smp(idx);
    trig    = t;
    tick();
    s_valid = 1'b0;
    trig    = 1'b0;
  endtask

  task automatic do_arm(input int p, input int q);
    pre_cnt  = AWIDTH'(p);
    post_cnt = AWIDTH'(q);
    arm      = 1'b1;
    tick();
    arm      = 1'b0;
  endtask

  task automatic rd_one(input string tag, input int addr, input logic [DW-1:0] exp);
    rd_en   = 1'b1;
    rd_addr = AWIDTH'(addr);
    tick();
    rd_en   = 1'b0;
    check({tag, "_vld_early"}, 64'(rd_valid), 64'd0);
    tick();
    check({tag, "_vld"}, 64'(rd_valid), 64'd1);
    check({tag, "_data"}, 64'(rd_data), 64'(exp));
  endtask

  task automatic rd_burst(input string tag, input int n, input int first_sample);
    for (int k = 0; k < n; k++) begin
      rd_en   = 1'b1;
      rd_addr = AWIDTH'(k);
      tick();
      if (k > 0) begin
        check({tag, "_vld"}, 64'(rd_valid), 64'd1);
        check({tag, "_data"}, 64'(rd_data), 64'(smp(first_sample + k - 1)));
      end
    end
    rd_en = 1'b0;
    tick();
    check({tag, "_vld_last"}, 64'(rd_valid), 64'd1);
    check({tag, "_data_last"}, 64'(rd_data), 64'(smp(first_sample + n - 1)));
    tick();
    check({tag, "_vld_off"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; abort = 1'b0; trig = 1'b0; s_valid = 1'b0;
    s_data = '0; rd_en = 1'b0; rd_addr = '0; pre_cnt = '0; post_cnt = '0;
    exp_ts = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_start", 64'(start_addr), 64'd0);
    check("rst_trig_ts", 64'(trig_ts), 64'd0);
    check("rst_rd_data", 64'(rd_data), 64'd0);

    // Basic capture: pre 4, post 4, trigger with sample 11
    do_arm(4, 4);
    check("t1_busy_arm", 64'(busy), 64'd1);
    for (int i = 0; i <= 10; i++) push(i, 1'b0);
    exp_ts = TS_EN ? cyc : 32'd0;
    push(11, 1'b1);
    push(12, 1'b0);
    push(13, 1'b0);
    check("t1_busy_post", 64'(busy), 64'd1);
    check("t1_done_post", 64'(done), 64'd0);
    push(14, 1'b0);
    check("t1_done", 64'(done), 64'd1);
    check("t1_busy_done", 64'(busy), 64'd0);
    check("t1_start", 64'(start_addr), 64'd7);
    check("t1_trig_ts", 64'(trig_ts), 64'(exp_ts));
    rd_one("t1_lat", 0, smp(7));
    rd_burst("t1_rd", 8, 7);
    rd_one("t1_oob", 20, '0);

    // Wrap-around: pre 6, post 8, trigger with sample 40
    do_arm(6, 8);
    for (int i = 0; i <= 39; i++) push(i, 1'b0);
    push(40, 1'b1);
    for (int i = 41; i <= 47; i++) push(i, 1'b0);
    check("t2_done", 64'(done), 64'd1);
    check("t2_start", 64'(start_addr), 64'd2);
    rd_burst("t2_rd", 14, 34);

    // Early trigger ignored in PRE; post 0 ends without writing the trigger sample
    do_arm(3, 0);
    push(100, 1'b1);
    check("t3_pre_busy", 64'(busy), 64'd1);
    check("t3_pre_done", 64'(done), 64'd0);
    for (int i = 101; i <= 105; i++) push(i, 1'b0);
    push(106, 1'b1);
    check("t3_done", 64'(done), 64'd1);
    check("t3_start", 64'(start_addr), 64'd3);
    rd_one("t3_oob", 25, '0);
    rd_one("t3_log2", 2, smp(105));
    rd_one("t3_log3", 3, smp(38));

    // Config error from IDLE, exact-fit acceptance, arm ignored while busy
    abort = 1'b1; tick(); abort = 1'b0;
    check("t4_abort_busy", 64'(busy), 64'd0);
    check("t4_abort_done", 64'(done), 64'd0);
    do_arm(10, 7);
    check("t4_cfg_err", 64'(cfg_err), 64'd1);
    check("t4_err_busy", 64'(busy), 64'd0);
    check("t4_err_done", 64'(done), 64'd0);
    tick();
    check("t4_cfg_err_pulse", 64'(cfg_err), 64'd0);
    do_arm(10, 6);
    check("t4_fit_busy", 64'(busy), 64'd1);
    check("t4_fit_err", 64'(cfg_err), 64'd0);
    do_arm(10, 7);
    check("t4_busy_arm_err", 64'(cfg_err), 64'd0);
    check("t4_busy_arm_busy", 64'(busy), 64'd1);

    // Abort in POST, then simultaneous arm and abort
    abort = 1'b1; tick(); abort = 1'b0;
    do_arm(2, 4);
    push(200, 1'b0);
    push(201, 1'b0);
    push(202, 1'b0);
    push(203, 1'b1);
    push(204, 1'b0);
    check("t5_post_busy", 64'(busy), 64'd1);
    check("t5_post_start", 64'(start_addr), 64'd1);
    abort = 1'b1;
    push(205, 1'b0);
    abort = 1'b0;
    check("t5_abort_busy", 64'(busy), 64'd0);
    check("t5_abort_done", 64'(done), 64'd0);
    abort = 1'b1;
    do_arm(2, 2);
    abort = 1'b0;
    check("t5_armabort_busy", 64'(busy), 64'd0);
    check("t5_armabort_err", 64'(cfg_err), 64'd0);

    // Reset mid-capture clears outputs but not RAM
    do_arm(2, 2);
    check("t6_busy", 64'(busy), 64'd1);
    push(300, 1'b0);
    push(301, 1'b0);
    rst = 1'b1;
    push(302, 1'b0);
    rst = 1'b0;
    check("t6_busy_rst", 64'(busy), 64'd0);
    check("t6_done_rst", 64'(done), 64'd0);
    check("t6_err_rst", 64'(cfg_err), 64'd0);
    check("t6_start_rst", 64'(start_addr), 64'd0);
    check("t6_vld_rst", 64'(rd_valid), 64'd0);
    check("t6_data_rst", 64'(rd_data), 64'd0);
    check("t6_ts_rst", 64'(trig_ts), 64'd0);
    rd_one("t6_keep0", 0, smp(300));
    rd_one("t6_keep3", 3, smp(203));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_capture_ram.md
Name: adc_capture_ram

Overview:
Multi-channel ADC capture buffer that supersedes the plain dual-port BRAM.
- Port A is driven internally by a capture FSM: circular writes of packed channel samples, pre-trigger retention, and a programmed post-trigger count.
- Port B is a registered read port addressed relative to capture start, so software reads sample 0 as the oldest pre-trigger sample.
- Sits between the ADC sample-assembly logic and the AXI/register read-out.

Parameters:
DWIDTH, 16, bits per channel sample
NCH, 4, channels per RAM word (word width = NCH*DWIDTH)
AWIDTH, 11, address/count width; must satisfy 2^AWIDTH >= MEM_SIZE
MEM_SIZE, 1300, RAM depth in words

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
arm  in  1  start capture (one-cycle pulse)
abort  in  1  force return to IDLE
trig  in  1  trigger strobe
pre_cnt  in  AWIDTH  pre-trigger samples, latched on arm
post_cnt  in  AWIDTH  post-trigger samples (trigger sample included), latched on arm
s_valid  in  1  sample strobe
s_data  in  NCH*DWIDTH  packed samples, ch0 in LSBs
busy  out  1  high in PRE, WAIT_TRIG and POST
done  out  1  high in DONE
cfg_err  out  1  one-cycle pulse: arm rejected
start_addr  out  AWIDTH  physical address of logical sample 0
trig_ts  out  32  trigger timestamp (optional feature)
rd_en  in  1  read request
rd_addr  in  AWIDTH  logical read index
rd_data  out  NCH*DWIDTH  read data
rd_valid  out  1  rd_data valid

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- On reset: state IDLE; busy, done, cfg_err, rd_valid = 0; start_addr, trig_ts, rd_data = 0; wr_ptr = 0. RAM contents are not cleared.
- States: IDLE, PRE, WAIT_TRIG, POST, DONE.
- IDLE/DONE + arm:
  - If pre_cnt + post_cnt > MEM_SIZE (AWIDTH+1-bit sum), pulse cfg_err and stay in the current state.
  - Otherwise latch pre_cnt and post_cnt, clear wr_ptr and the fill counter, and go to PRE.
- arm in PRE, WAIT_TRIG or POST is ignored. abort wins over arm and over trig and returns to IDLE from any state next cycle.
- Write rule: in PRE, WAIT_TRIG and POST, each s_valid writes s_data to ram[wr_ptr]. wr_ptr increments and wraps from MEM_SIZE-1 to 0. Write latency is 1 cycle.
- PRE: the fill counter counts writes. Go to WAIT_TRIG when fill == pre_cnt; if pre_cnt == 0, go after one cycle. trig is ignored in PRE.
- WAIT_TRIG: keep writing circularly. On trig, start_addr <= (wr_ptr - pre_cnt) mod MEM_SIZE.
  - post_cnt == 0: go to DONE; the trigger-cycle sample is not written.
  - Otherwise go to POST with remaining = post_cnt. If s_valid is high in the trigger cycle, that sample is written and counts as post sample 1.
- POST: decrement remaining on each write. Go to DONE on the write that brings remaining to 0. trig is ignored.
- DONE: no writes; done stays high until arm, abort or rst.
- Read path (2-cycle latency):
  - Cycle 1: phys <= start_addr + rd_addr, minus MEM_SIZE if the sum is >= MEM_SIZE.
  - Cycle 2: rd_data <= ram[phys].
  - rd_valid follows rd_en delayed by 2 cycles; back-to-back reads give one result per cycle.
  - rd_addr >= MEM_SIZE returns rd_data = 0, with rd_valid still asserted.
- Reads are legal in any state. Data read while busy is unspecified but never disturbs the write path.
- If a read and a write hit the same address in the same cycle, the read returns the old data.

Optional Feature:
ADC_CAP_TIMESTAMP_EN
- Defined: a 32-bit free-running counter, cleared by rst and wrapping at 2^32, is latched into trig_ts in the trigger cycle. The latched value holds until the next trigger or rst.
- Undefined: no counter is built and trig_ts is tied to 0. Everything else is unchanged.

Decomposition:
- Package adc_cap_pkg: state enum (IDLE, PRE, WAIT_TRIG, POST, DONE), read-latency constant RD_LAT = 2, timestamp width TS_W = 32.
- Sub-module adc_cap_dpram: generic simple dual-port block RAM, one write port and one registered read port, width NCH*DWIDTH, depth MEM_SIZE, RAM_STYLE block.
- The FSM, pointer logic and address rotation live in adc_capture_ram.

Test Plan:
- Basic capture (MEM_SIZE=16): pre=4, post=4, s_valid continuous with data equal to the sample index, trig after sample 10 → DONE; logical 0..7 read back as 7..14, and rd_valid appears 2 cycles after each rd_en.
- Wrap-around (MEM_SIZE=16): pre=6, post=8, trigger at sample 40 → start_addr = (40-6) mod 16 = 2; logical reads return samples 34..47 in order.
- Early trig and post=0: trig during PRE is ignored. pre=3, post=0, trig in WAIT_TRIG → DONE next cycle with no extra write.
- Config error (MEM_SIZE=16): arm with pre=10, post=7 → one-cycle cfg_err, state stays IDLE, busy = 0.
- Abort and reset: abort in POST → IDLE next cycle, busy = 0, done = 0. Same-cycle arm and abort → IDLE. rst mid-capture → all outputs 0; RAM contents survive.
- Timestamp (macro defined): trig in reset-relative cycle 1000 → trig_ts = 1000. Macro undefined → trig_ts = 0.
